decode_out_buffer: RTL
======================

# decode_out_buffer

Parametrised, elastic pipeline buffer for the LC3 decode-to-execute bundle (W_Control, E_Control, IR, npc_out, Mem_Control). It sits between the Decode stage and the Execute stage. It replaces the fixed single-register decode output with a DEPTH-entry FIFO that uses a valid/ready handshake on both sides, adds a synchronous flush for branch redirect, and exposes an occupancy count. Field widths are parameters, so the same block serves widened-datapath variants.

## Interface

Parameters:
- DATA_W, 16: width of IR and npc fields
- E_CTRL_W, 6: width of E_Control
- W_CTRL_W, 2: width of W_Control
- DEPTH, 2: number of entries; power of two, ≥ 2

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous discard of all entries
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  buffer can accept a bundle
- W_Control_in  in  W_CTRL_W  writeback control
- E_Control_in  in  E_CTRL_W  execute control
- IR_in  in  DATA_W  instruction
- npc_in  in  DATA_W  next PC
- Mem_Control_in  in  1  memory control
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- W_Control, E_Control, IR, npc_out, Mem_Control  out  as inputs  head-entry fields
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation

- A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. in_ready does not depend on out_ready, so a full buffer never accepts a bundle, even in a cycle that pops.
- out_valid = (count != 0).
- When out_valid=0, all output fields are driven to 0. This is a NOP bundle with IR=16'h0000.
- Storage is a circular array with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits wide. The pointers wrap naturally from DEPTH-1 to 0.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push into an empty buffer: the entry is visible on the outputs the next cycle. There is no same-cycle bypass.
- flush=1:
  - On the next edge, count becomes 0 and wr_ptr = rd_ptr = 0.
  - Any push in the flush cycle is blocked, because in_ready=0.
  - A pop in the flush cycle is still reported to downstream (out_valid is unaffected during the flush cycle), but the entry is discarded along with the others.
- Reset (asynchronous): count=0, both pointers=0, out_valid=0, in_ready=1 (when flush=0), all output fields=0. Storage contents are don't-care.
  - Reset asserted mid-transfer aborts the transfer; no partial entry survives.

## Timing

- Input-to-output latency is 1 cycle when the buffer is empty. Otherwise it is 1 cycle plus the number of entries ahead.
- Throughput is 1 bundle/cycle in steady state when 0 < count < DEPTH.
- in_ready and out_valid are combinational functions of registered count and the flush input only. There are no combinational paths from in_valid to in_ready, or from out_ready to out_valid.
- Output fields are a registered-array read addressed by rd_ptr, gated by out_valid.
- count is registered and updates on the edge following the handshake.

## Structure

- Package decode_out_buf_pkg:
  - default width localparams
  - field offset localparams within the flattened bundle
  - function bundle_w(data_w, e_w, w_w) = 2*data_w + e_w + w_w + 1
- Sub-module decode_out_buf_mem: DEPTH × bundle_w register array, with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- The top level holds the pointers, count, handshake logic and output gating.

## Test plan

- Reset then idle: count=0, out_valid=0, in_ready=1, IR=16'h0000.
- Single push of IR=16'h1234, npc=16'h3001, E_Control=6'h2A, W_Control=2'b01, Mem_Control=1 with out_ready=0:
  - next cycle: out_valid=1, count=1, fields match
  - pop with out_ready=1: count=0, outputs return to 0
- DEPTH=2 fill with out_ready=0, push A then B:
  - count=2, in_ready=0
  - a third push with in_valid=1 is not accepted
  - drain order is A then B
- Continuous stream of 8 bundles with in_valid and out_ready held at 1:
  - one pop per cycle after the first
  - pointers wrap past DEPTH-1
  - order is preserved and count stays at 1
- count=2 and flush=1 together with in_valid=1:
  - in_ready=0 that cycle
  - next cycle: count=0, out_valid=0
  - the flushed input never appears at the output
- Reset asserted between clock edges while count=2: out_valid drops to 0 and count to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_out_buf_pkg.sv
// Shared widths and bundle layout for the decode-to-execute output buffer.
// Bundle packing, MSB to LSB: {W_Control, E_Control, IR, npc, Mem_Control}.
package decode_out_buf_pkg;

   localparam int unsigned DATA_W_DEF   = 16;
   localparam int unsigned E_CTRL_W_DEF = 6;
   localparam int unsigned W_CTRL_W_DEF = 2;
   localparam int unsigned DEPTH_DEF    = 2;

   localparam int unsigned MEM_OFS = 0;
   localparam int unsigned NPC_OFS = MEM_OFS + 1;
   localparam int unsigned IR_OFS  = NPC_OFS + DATA_W_DEF;
   localparam int unsigned E_OFS   = IR_OFS + DATA_W_DEF;
   localparam int unsigned W_OFS   = E_OFS + E_CTRL_W_DEF;

   function automatic int unsigned bundle_w(input int unsigned data_w,
                                            input int unsigned e_w,
                                            input int unsigned w_w);
      return 2 * data_w + e_w + w_w + 1;
   endfunction

endpackage

// File: rtl/decode_out_buffer_if.sv
// Decode-side and execute-side handshake plus bundle fields of the output buffer.
interface decode_out_buffer_if
   import decode_out_buf_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned E_CTRL_W = E_CTRL_W_DEF,
   parameter int unsigned W_CTRL_W = W_CTRL_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF
);
   logic                       in_valid;
   logic                       in_ready;
   logic [W_CTRL_W-1:0]        W_Control_in;
   logic [E_CTRL_W-1:0]        E_Control_in;
   logic [DATA_W-1:0]          IR_in;
   logic [DATA_W-1:0]          npc_in;
   logic                       Mem_Control_in;
   logic                       out_valid;
   logic                       out_ready;
   logic [W_CTRL_W-1:0]        W_Control;
   logic [E_CTRL_W-1:0]        E_Control;
   logic [DATA_W-1:0]          IR;
   logic [DATA_W-1:0]          npc_out;
   logic                       Mem_Control;
   logic [$clog2(DEPTH+1)-1:0] count;

   modport master (
      output in_valid, W_Control_in, E_Control_in, IR_in, npc_in, Mem_Control_in, out_ready,
      input  in_ready, out_valid, W_Control, E_Control, IR, npc_out, Mem_Control, count
   );

   modport slave (
      input  in_valid, W_Control_in, E_Control_in, IR_in, npc_in, Mem_Control_in, out_ready,
      output in_ready, out_valid, W_Control, E_Control, IR, npc_out, Mem_Control, count
   );
endinterface

// File: rtl/decode_out_buf_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module decode_out_buf_mem #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 41
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // Storage needs no reset: count gates every read of stale contents.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/decode_out_buffer.sv
// Elastic DEPTH-entry FIFO between Decode and Execute with flush and occupancy count.
module decode_out_buffer
   import decode_out_buf_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned E_CTRL_W = E_CTRL_W_DEF,
   parameter int unsigned W_CTRL_W = W_CTRL_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF
) (
   input logic                clock,
   input logic                reset,
   input logic                flush,
   decode_out_buffer_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned BW    = bundle_w(DATA_W, E_CTRL_W, W_CTRL_W);
   localparam int unsigned NPC_LO = 1;
   localparam int unsigned IR_LO  = NPC_LO + DATA_W;
   localparam int unsigned E_LO   = IR_LO + DATA_W;
   localparam int unsigned W_LO   = E_LO + E_CTRL_W;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;
   logic [BW-1:0]    wdata, rdata;

   assign bus.in_ready  = (count_q < CNT_W'(DEPTH)) && !flush;
   assign bus.out_valid = (count_q != '0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;
   assign bus.count     = count_q;

   assign wdata = {bus.W_Control_in, bus.E_Control_in, bus.IR_in, bus.npc_in, bus.Mem_Control_in};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // A pop seen downstream this cycle is discarded along with the rest.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   decode_out_buf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (BW)
   ) u_mem (
      .clock (clock),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   // An empty buffer presents an all-zero NOP bundle.
   always_comb begin
      bus.W_Control   = '0;
      bus.E_Control   = '0;
      bus.IR          = '0;
      bus.npc_out     = '0;
      bus.Mem_Control = 1'b0;
      if (bus.out_valid) begin
         bus.W_Control   = rdata[W_LO +: W_CTRL_W];
         bus.E_Control   = rdata[E_LO +: E_CTRL_W];
         bus.IR          = rdata[IR_LO +: DATA_W];
         bus.npc_out     = rdata[NPC_LO +: DATA_W];
         bus.Mem_Control = rdata[0];
      end
   end
endmodule
